motion_executor: RTL and testbench

//  Receiving end of the semi-auto/auto navigation command path: accepts a 4-bit moving-state

---
 rtl/motion_executor.sv | 247 ++++++++++++++++++++++++
 tb/tb_motion_executor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/motion_executor.sv
// -----------------------------------------------------------------------------
// motion_executor
//
// Purpose:
//   This is the receiving end of the navigation command path. It accepts a
//   4-bit moving-state command over a valid/ready handshake and drives the
//   chassis motor enables and their indicator lights. Turns are timed on an
//   internal tick of TICK_DIV sys_clk cycles. After each turn there is a
//   settle period with every motor off. When the settle period ends, done
//   pulses for one cycle.
//
// Ports:
//   sys_clk             in   core clock
//   rst                 in   asynchronous reset, active-high
//   cmd_valid           in   command offered this cycle
//   cmd[3:0]            in   0000 STOP, 0001 MOVE_FORWARD, 0010 MOVE_BACK,
//                            0100 TURN_LEFT, 1000 TURN_RIGHT, 1100 AROUND
//   cmd_ready           out  command can be accepted this cycle (IDLE/RUN)
//   done                out  one-cycle pulse at the end of turn + settle
//   cmd_err             out  one-cycle pulse: accepted code not in table
//   move_forward        out  forward motor enable
//   move_backward       out  reverse motor enable
//   turn_left           out  left-turn motor enable
//   turn_right          out  right-turn motor enable
//   *_light             out  indicator for the matching enable
//
// Configuration:
//   MOTION_EXECUTOR_BLINK_EN
//     Defined:   while a turn enable is high, its light toggles every 25 ticks.
//                The light starts lit when the turn begins.
//     Undefined: each turn light is a steady copy of its enable.
//   The motor outputs are the same in both builds.
// -----------------------------------------------------------------------------
module motion_executor #(
  parameter int TICK_DIV     = 100_000,
  parameter int TURN_TICKS   = 200,
  parameter int SETTLE_TICKS = 50
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic       done,
  output logic       cmd_err,
  output logic       move_forward,
  output logic       move_backward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       move_forward_light,
  output logic       move_backward_light,
  output logic       turn_left_light,
  output logic       turn_right_light
);

  localparam int            PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
  localparam logic [15:0]   TURN_LIMIT   = 16'(TURN_TICKS);
  localparam logic [15:0]   AROUND_LIMIT = 16'(2 * TURN_TICKS);
  localparam logic [15:0]   SETTLE_LIMIT = 16'(SETTLE_TICKS);

  localparam logic [3:0] CMD_STOP   = 4'b0000;
  localparam logic [3:0] CMD_FWD    = 4'b0001;
  localparam logic [3:0] CMD_BACK   = 4'b0010;
  localparam logic [3:0] CMD_LEFT   = 4'b0100;
  localparam logic [3:0] CMD_RIGHT  = 4'b1000;
  localparam logic [3:0] CMD_AROUND = 4'b1100;

  // Motor/light vector bit order: {forward, backward, left, right}
  localparam logic [3:0] M_OFF   = 4'b0000;
  localparam logic [3:0] M_FWD   = 4'b1000;
  localparam logic [3:0] M_BACK  = 4'b0100;
  localparam logic [3:0] M_LEFT  = 4'b0010;
  localparam logic [3:0] M_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_TURN   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [15:0]   ticks_r;
  logic [15:0]   limit_r;
  logic [3:0]    motor_r;
  logic [3:0]    light_r;
  logic          cmd_ready_r;
  logic          done_r;
  logic          cmd_err_r;

`ifdef MOTION_EXECUTOR_BLINK_EN
  localparam logic [4:0] BLINK_LAST = 5'd24;
  logic [4:0] blink_r;
`endif

  logic          tick_s;
  logic          last_tick_s;
  logic          accept_s;
  state_t        dec_state_s;
  logic [3:0]    dec_motor_s;
  logic [15:0]   dec_limit_s;
  logic          dec_err_s;

  // Tick strobe, end-of-period detect and handshake qualifier
  always_comb begin
    tick_s      = (presc_r == PRESC_LAST);
    last_tick_s = tick_s && (ticks_r == (limit_r - 16'd1));
    accept_s    = cmd_valid && cmd_ready_r;
  end

  // Command decode: target state, motor pattern, tick limit and error flag
  always_comb begin
    dec_state_s = ST_IDLE;
    dec_motor_s = M_OFF;
    dec_limit_s = TURN_LIMIT;
    dec_err_s   = 1'b0;
    case (cmd)
      CMD_STOP: begin
        dec_state_s = ST_IDLE;
        dec_motor_s = M_OFF;
      end
      CMD_FWD: begin
        dec_state_s = ST_RUN;
        dec_motor_s = M_FWD;
      end
      CMD_BACK: begin
        dec_state_s = ST_RUN;
        dec_motor_s = M_BACK;
      end
      CMD_LEFT: begin
        dec_state_s = ST_TURN;
        dec_motor_s = M_LEFT;
      end
      CMD_RIGHT: begin
        dec_state_s = ST_TURN;
        dec_motor_s = M_RIGHT;
      end
      CMD_AROUND: begin
        dec_state_s = ST_TURN;
        dec_motor_s = M_RIGHT;
        dec_limit_s = AROUND_LIMIT;
      end
      default: begin
        dec_state_s = ST_IDLE;
        dec_motor_s = M_OFF;
        dec_err_s   = 1'b1;
      end
    endcase
  end

  // Executor FSM with timing counters and registered outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      presc_r     <= '0;
      ticks_r     <= 16'd0;
      limit_r     <= TURN_LIMIT;
      motor_r     <= M_OFF;
      light_r     <= M_OFF;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      cmd_err_r   <= 1'b0;
`ifdef MOTION_EXECUTOR_BLINK_EN
      blink_r     <= 5'd0;
`endif
    end else begin
      done_r    <= 1'b0;
      cmd_err_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_RUN: begin
`ifdef MOTION_EXECUTOR_BLINK_EN
          presc_r <= tick_s ? '0 : presc_r + PRESC_ONE;
`endif
          if (accept_s) begin
            // Every accepted command restarts the timebase, so a turn
            // always lasts exactly limit*TICK_DIV cycles from entry
            state_r     <= dec_state_s;
            motor_r     <= dec_motor_s;
            light_r     <= dec_motor_s;
            limit_r     <= dec_limit_s;
            cmd_err_r   <= dec_err_s;
            cmd_ready_r <= (dec_state_s != ST_TURN);
            presc_r     <= '0;
            ticks_r     <= 16'd0;
`ifdef MOTION_EXECUTOR_BLINK_EN
            blink_r     <= 5'd0;
`endif
          end
        end
        ST_TURN: begin
          presc_r <= tick_s ? '0 : presc_r + PRESC_ONE;
          if (last_tick_s) begin
            state_r <= ST_SETTLE;
            motor_r <= M_OFF;
            light_r <= M_OFF;
            limit_r <= SETTLE_LIMIT;
            presc_r <= '0;
            ticks_r <= 16'd0;
          end else if (tick_s) begin
            ticks_r <= ticks_r + 16'd1;
`ifdef MOTION_EXECUTOR_BLINK_EN
            // XOR with the motor pattern flips only the active turn light
            if (blink_r == BLINK_LAST) begin
              blink_r <= 5'd0;
              light_r <= light_r ^ motor_r;
            end else begin
              blink_r <= blink_r + 5'd1;
            end
`endif
          end
        end
        ST_SETTLE: begin
          presc_r <= tick_s ? '0 : presc_r + PRESC_ONE;
          if (last_tick_s) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b1;
            cmd_ready_r <= 1'b1;
          end else if (tick_s) begin
            ticks_r <= ticks_r + 16'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          motor_r     <= M_OFF;
          light_r     <= M_OFF;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready           = cmd_ready_r;
  assign done                = done_r;
  assign cmd_err             = cmd_err_r;
  assign move_forward        = motor_r[3];
  assign move_backward       = motor_r[2];
  assign turn_left           = motor_r[1];
  assign turn_right          = motor_r[0];
  assign move_forward_light  = light_r[3];
  assign move_backward_light = light_r[2];
  assign turn_left_light     = light_r[1];
  assign turn_right_light    = light_r[0];

endmodule

// File: tb/tb_motion_executor.sv
// -----------------------------------------------------------------------------
// tb_motion_executor
//
// Self-checking bench for motion_executor. The main instance uses
// TICK_DIV=4, TURN_TICKS=3 and SETTLE_TICKS=2. Each time a command is
// accepted, the bench pushes the output vector expected for every following
// cycle onto a queue. Each cycle it pops one entry and compares it with the
// DUT outputs on the falling edge.
//
// A second instance (TICK_DIV=2, TURN_TICKS=60) checks turn_left_light during
// a long left turn. The expected light depends on MOTION_EXECUTOR_BLINK_EN.
// -----------------------------------------------------------------------------
module tb_motion_executor;

  localparam int TB_DIV    = 4;
  localparam int TB_TURN   = 3;
  localparam int TB_SETTLE = 2;

  localparam logic [3:0] C_STOP   = 4'b0000;
  localparam logic [3:0] C_FWD    = 4'b0001;
  localparam logic [3:0] C_BACK   = 4'b0010;
  localparam logic [3:0] C_LEFT   = 4'b0100;
  localparam logic [3:0] C_RIGHT  = 4'b1000;
  localparam logic [3:0] C_AROUND = 4'b1100;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready, done, cmd_err;
  logic       move_forward, move_backward, turn_left, turn_right;
  logic       move_forward_light, move_backward_light, turn_left_light, turn_right_light;

  logic       b_valid;
  logic [3:0] b_cmd;
  logic       b_ready, b_done, b_err;
  logic       b_fwd, b_back, b_left, b_right;
  logic       b_fwd_l, b_back_l, b_left_l, b_right_l;

  always #5 sys_clk = ~sys_clk;

  motion_executor #(.TICK_DIV(TB_DIV), .TURN_TICKS(TB_TURN), .SETTLE_TICKS(TB_SETTLE)) dut (
    .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .done(done), .cmd_err(cmd_err),
    .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .move_forward_light(move_forward_light), .move_backward_light(move_backward_light),
    .turn_left_light(turn_left_light), .turn_right_light(turn_right_light)
  );

  motion_executor #(.TICK_DIV(2), .TURN_TICKS(60), .SETTLE_TICKS(TB_SETTLE)) dut_blink (
    .sys_clk(sys_clk), .rst(rst), .cmd_valid(b_valid), .cmd(b_cmd),
    .cmd_ready(b_ready), .done(b_done), .cmd_err(b_err),
    .move_forward(b_fwd), .move_backward(b_back),
    .turn_left(b_left), .turn_right(b_right),
    .move_forward_light(b_fwd_l), .move_backward_light(b_back_l),
    .turn_left_light(b_left_l), .turn_right_light(b_right_l)
  );

  // Observed vector: {ready, done, err, motors fwd/back/left/right, lights same order}
  logic [10:0] obs_s;
  assign obs_s = {cmd_ready, done, cmd_err,
                  move_forward, move_backward, turn_left, turn_right,
                  move_forward_light, move_backward_light, turn_left_light, turn_right_light};

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          cyc           = 0;
  string       phase         = "reset";
  logic [10:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  function automatic logic [10:0] ev(input logic r, input logic d, input logic e, input logic [3:0] m);
    return {r, d, e, m, m};
  endfunction

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'b0000));
  endtask

  // Expected outputs for the cycles after command c is accepted
  task automatic plan(input logic [3:0] c, input int tail);
    int         lim;
    logic [3:0] m;
    exp_q.delete();
    case (c)
      C_STOP: push_idle(tail);
      C_FWD:  repeat (tail) exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'b1000));
      C_BACK: repeat (tail) exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'b0100));
      C_LEFT, C_RIGHT, C_AROUND: begin
        m   = (c == C_LEFT) ? 4'b0010 : 4'b0001;
        lim = (c == C_AROUND) ? 2 * TB_TURN : TB_TURN;
        repeat (lim * TB_DIV) exp_q.push_back(ev(1'b0, 1'b0, 1'b0, m));
        repeat (TB_SETTLE * TB_DIV) exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'b0000));
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 4'b0000));
        push_idle(tail);
      end
      default: begin
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 4'b0000));
        push_idle(tail);
      end
    endcase
  endtask

  // One cycle: compare this cycle's outputs, then drive this cycle's inputs
  task automatic step(input logic v, input logic [3:0] c, input bit replan, input int tail);
    @(negedge sys_clk);
    if (exp_q.size() > 0) begin
      check_eq(phase, {21'd0, obs_s}, {21'd0, exp_q.pop_front()});
    end
    cmd_valid = v;
    cmd       = c;
    if (replan) begin
      plan(c, tail);
      cyc = 0;
    end else begin
      cyc++;
    end
  endtask

  function automatic logic blink_lit(input int c);
`ifdef MOTION_EXECUTOR_BLINK_EN
    return (((c - 1) / 50) % 2) == 0;
`else
    return (c >= 1);
`endif
  endfunction

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 4'b0000;
    b_valid   = 1'b0;
    b_cmd     = 4'b0000;
    #2 rst = 1'b1;
    #1 check_eq("reset_state", {21'd0, obs_s}, {21'd0, ev(1'b1, 1'b0, 1'b0, 4'b0000)});
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    push_idle(3);
    repeat (3) step(1'b0, 4'b0000, 1'b0, 0);

    // Forward, then preempted by backward at cycle 10
    phase = "forward";
    step(1'b1, C_FWD, 1'b1, 10);
    repeat (9) step(1'b0, 4'b0000, 1'b0, 0);
    phase = "backward";
    step(1'b1, C_BACK, 1'b1, 5);
    repeat (4) step(1'b0, 4'b0000, 1'b0, 0);

    // Illegal code from RUN
    phase = "illegal_code";
    step(1'b1, 4'b0110, 1'b1, 4);
    repeat (5) step(1'b0, 4'b0000, 1'b0, 0);

    // Left turn + settle + done
    phase = "turn_left";
    step(1'b1, C_LEFT, 1'b1, 3);
    repeat (24) step(1'b0, 4'b0000, 1'b0, 0);

    // Around with cmd_valid held high; only taken once ready returns
    phase = "around";
    step(1'b1, C_AROUND, 1'b1, 0);
    repeat (32) step(1'b1, C_LEFT, 1'b0, 0);
    phase = "around_done";
    step(1'b1, C_STOP, 1'b1, 3);
    repeat (3) step(1'b0, 4'b0000, 1'b0, 0);

    // Right turn
    phase = "turn_right";
    step(1'b1, C_RIGHT, 1'b1, 2);
    repeat (23) step(1'b0, 4'b0000, 1'b0, 0);

    // Reset in the middle of a turn: immediate abort, no done later
    phase = "pre_reset_turn";
    step(1'b1, C_LEFT, 1'b1, 0);
    repeat (5) step(1'b0, 4'b0000, 1'b0, 0);
    #2 rst = 1'b1;
    #1 check_eq("reset_mid_turn", {21'd0, obs_s}, {21'd0, ev(1'b1, 1'b0, 1'b0, 4'b0000)});
    @(negedge sys_clk);
    rst = 1'b0;
    exp_q.delete();
    push_idle(25);
    phase = "after_reset";
    repeat (25) step(1'b0, 4'b0000, 1'b0, 0);

    // Long left turn on the second instance: light pattern vs enable
    b_valid = 1'b1;
    b_cmd   = C_LEFT;
    @(negedge sys_clk);
    b_valid = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      cyc = c;
      check_eq("blink_turn", {30'd0, b_left, b_left_l}, {30'd0, 1'b1, blink_lit(c)});
      @(negedge sys_clk);
    end
    cyc = 121;
    check_eq("blink_turn_end", {30'd0, b_left, b_left_l}, {30'd0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
